// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: per-requester request vectors, the shared framebuffer port and status.
// The slave modport is the arbiter; the master modport is the requester/framebuffer side.
interface vram_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GRANT_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_sel_i;
    logic [NUM_REQ-1:0]    req_wr_i;
    logic [4*NUM_REQ-1:0]  req_mask_i;
    logic [24*NUM_REQ-1:0] req_address_i;
    logic [16*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ack_o;
    logic [15:0]           req_data_o;

    logic                  fb_sel_o;
    logic                  fb_wr_o;
    logic [3:0]            fb_mask_o;
    logic [23:0]           fb_address_o;
    logic [15:0]           fb_data_o;
    logic                  fb_ack_i;
    logic [15:0]           fb_data_i;

    logic [GRANT_W-1:0]    grant_o;
    logic                  busy_o;
    logic                  timeout_o;

    modport slave (
        input  req_sel_i, req_wr_i, req_mask_i, req_address_i, req_data_i,
        input  fb_ack_i, fb_data_i,
        output req_ack_o, req_data_o,
        output fb_sel_o, fb_wr_o, fb_mask_o, fb_address_o, fb_data_o,
        output grant_o, busy_o, timeout_o
    );

    modport master (
        output req_sel_i, req_wr_i, req_mask_i, req_address_i, req_data_i,
        output fb_ack_i, fb_data_i,
        input  req_ack_o, req_data_o,
        input  fb_sel_o, fb_wr_o, fb_mask_o, fb_address_o, fb_data_o,
        input  grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing the framebuffer's single VRAM port among NUM_REQ requesters.
// Define VRAM_ARBITER_TIMEOUT_EN to abort transactions stalled in WAIT for TIMEOUT_CYCLES.
module vram_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset_i,
    vram_arbiter_if.slave bus
);
    localparam int GRANT_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("vram_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [GRANT_W-1:0] last;
    logic [GRANT_W-1:0] winner;
    logic               any_req;
    logic               timeout_hit;

    logic               fb_sel_q;
    logic               fb_wr_q;
    logic [3:0]         fb_mask_q;
    logic [23:0]        fb_address_q;
    logic [15:0]        fb_data_q;
    logic [NUM_REQ-1:0] req_ack_q;
    logic [15:0]        req_data_q;
    logic [GRANT_W-1:0] grant_q;

    logic [3:0]         mask_arr    [NUM_REQ];
    logic [23:0]        address_arr [NUM_REQ];
    logic [15:0]        data_arr    [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign mask_arr[i]    = bus.req_mask_i[4*i +: 4];
        assign address_arr[i] = bus.req_address_i[24*i +: 24];
        assign data_arr[i]    = bus.req_data_i[16*i +: 16];
    end

    // Winner is the first requesting index after the last one served, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        any_req = 1'b0;
        winner  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [GRANT_W-1:0] idx;
            idx = GRANT_W'((int'(last) + k) % NUM_REQ);
            if (!any_req && bus.req_sel_i[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (any_req) state_next = S_WAIT;
            S_WAIT:    if (bus.fb_ack_i || timeout_hit) state_next = S_RELEASE;
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Downstream fields are captured at grant and frozen until the transaction ends.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            fb_sel_q     <= 1'b0;
            fb_wr_q      <= 1'b0;
            fb_mask_q    <= '0;
            fb_address_q <= '0;
            fb_data_q    <= '0;
            req_ack_q    <= '0;
            req_data_q   <= '0;
            grant_q      <= '0;
            last         <= GRANT_W'(NUM_REQ - 1);
        end else begin
            req_ack_q <= '0;
            case (state)
                S_IDLE: begin
                    fb_sel_q <= any_req;
                    if (any_req) begin
                        fb_wr_q      <= bus.req_wr_i[winner];
                        fb_mask_q    <= mask_arr[winner];
                        fb_address_q <= address_arr[winner];
                        fb_data_q    <= data_arr[winner];
                        grant_q      <= winner;
                    end
                end
                S_WAIT: begin
                    if (bus.fb_ack_i || timeout_hit) begin
                        fb_sel_q           <= 1'b0;
                        req_ack_q[grant_q] <= 1'b1;
                        req_data_q         <= bus.fb_ack_i ? bus.fb_data_i : 16'h0000;
                        last               <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VRAM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // An ack on the expiry cycle takes precedence over the abort.
    assign timeout_hit = (state == S_WAIT) && !bus.fb_ack_i &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state != S_WAIT) begin
                wait_cnt <= '0;
            end else if (!timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.fb_sel_o     = fb_sel_q;
    assign bus.fb_wr_o      = fb_wr_q;
    assign bus.fb_mask_o    = fb_mask_q;
    assign bus.fb_address_o = fb_address_q;
    assign bus.fb_data_o    = fb_data_q;
    assign bus.req_ack_o    = req_ack_q;
    assign bus.req_data_o   = req_data_q;
    assign bus.grant_o      = grant_q;
    assign bus.busy_o       = (state != S_IDLE);
endmodule
